stimulus_completion_tracker: RTL

- Parametrised completion tracker and store-operand sink for the verilator top-level bench around rvv_core.
- Tracks per-instruction completion out of order using an ID bitmap.
- Sinks store operands with selectable backpressure patterns.
- Detects protocol errors: illegal instructions, duplicate or out-of-range IDs, surplus store operands, and stalls.
- Raises a registered sim_done_o or sim_error_o for the bench top to act on.

---
 rtl/tb_pkg.sv | 27 ++
 rtl/tb_grant_gen.sv | 40 ++++
 rtl/stimulus_completion_tracker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tb_pkg.sv
// Shared types for the stimulus completion tracker: FSM states, error codes
// and the grant LFSR taps/step function.
package tb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DONE  = 2'd1,
        ERROR = 2'd2
    } tracker_state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ILLEGAL   = 3'd1,
        ERR_DUP_ID    = 3'd2,
        ERR_ID_RANGE  = 3'd3,
        ERR_STORE_OVF = 3'd4,
        ERR_TIMEOUT   = 3'd5
    } tracker_err_e;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/tb_grant_gen.sv
// Store-operand grant pattern generator: always, alternating, or LFSR-driven.
// Grant is combinational from valid and is forced low while reset is high.
module tb_grant_gen
    import tb_pkg::*;
#(
    parameter int          GntMode  = 0,
    parameter logic [15:0] LfsrSeed = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic gnt_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        alt_q, alt_d;
    logic        pattern;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
        alt_d  = valid_i ? ~alt_q : alt_q;
        case (GntMode)
            1:       pattern = alt_q;
            2:       pattern = lfsr_q[0];
            default: pattern = 1'b1;
        endcase
        gnt_o = valid_i & pattern & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
            alt_q  <= 1'b1;
        end else begin
            lfsr_q <= lfsr_d;
            alt_q  <= alt_d;
        end
    end

endmodule

// File: rtl/stimulus_completion_tracker.sv
// Out-of-order completion tracker and store-operand sink for the rvv_core bench.
// Define STIMULUS_TRACKER_CHECKSUM_EN to add a rotate-xor checksum of accepted stores.
module stimulus_completion_tracker
    import tb_pkg::*;
#(
    parameter int          NumInsn       = 8,
    parameter int          InsnIdWidth   = 4,
    parameter int          XlenWidth     = 64,
    parameter int          DataWidth     = 64,
    parameter int          NumStoreOps   = 8,
    parameter int          GntMode       = 0,
    parameter logic [15:0] LfsrSeed      = 16'hACE1,
    parameter int          TimeoutCycles = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               done_i,
    input  logic [InsnIdWidth-1:0]             done_insn_id_i,
    input  logic                               illegal_insn_i,
    input  logic [XlenWidth-1:0]               result_i,
    input  logic                               store_op_valid_i,
    input  logic [DataWidth-1:0]               store_op_i,
    output logic                               store_op_gnt_o,
    output logic                               sim_done_o,
    output logic                               sim_error_o,
    output logic [2:0]                         error_code_o,
    output logic [$clog2(NumInsn+1)-1:0]       done_cnt_o,
    output logic [$clog2(NumStoreOps+1)-1:0]   store_cnt_o,
    output logic [XlenWidth-1:0]               last_result_o
`ifdef STIMULUS_TRACKER_CHECKSUM_EN
    ,
    output logic [DataWidth-1:0]               store_checksum_o
`endif
);

    localparam int DoneCntW  = $clog2(NumInsn + 1);
    localparam int StoreCntW = $clog2(NumStoreOps + 1);
    localparam int IdleW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int IdxW      = (NumInsn > 1) ? $clog2(NumInsn) : 1;

    localparam logic [InsnIdWidth:0] NumInsnW = (InsnIdWidth + 1)'(NumInsn);
    localparam logic [StoreCntW-1:0] StoreMax = StoreCntW'(NumStoreOps);
    localparam logic [IdleW-1:0]     IdleMax  = IdleW'(TimeoutCycles - 1);

    tracker_state_e         state_q, state_d;
    tracker_err_e           err_code_q, err_code_d;
    tracker_err_e           err;
    logic [NumInsn-1:0]     bitmap_q, bitmap_d;
    logic [DoneCntW-1:0]    done_cnt_q, done_cnt_d;
    logic [StoreCntW-1:0]   store_cnt_q, store_cnt_d;
    logic [XlenWidth-1:0]   last_result_q, last_result_d;
    logic [IdleW-1:0]       idle_q, idle_d;
    logic                   sim_done_q, sim_done_d;
    logic                   sim_error_q, sim_error_d;
    logic                   acc_store;
    logic                   id_in_range;
    logic                   id_seen;
    logic [IdxW-1:0]        id_idx;

    tb_grant_gen #(
        .GntMode  (GntMode),
        .LfsrSeed (LfsrSeed)
    ) u_grant_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (store_op_valid_i),
        .gnt_o   (store_op_gnt_o)
    );

    always_comb begin
        acc_store     = store_op_valid_i & store_op_gnt_o;
        id_idx        = done_insn_id_i[IdxW-1:0];
        id_in_range   = ({1'b0, done_insn_id_i} < NumInsnW);
        id_seen       = bitmap_q[id_idx];
        err           = ERR_NONE;
        state_d       = state_q;
        err_code_d    = err_code_q;
        bitmap_d      = bitmap_q;
        done_cnt_d    = done_cnt_q;
        store_cnt_d   = store_cnt_q;
        last_result_d = last_result_q;
        idle_d        = idle_q;

        case (state_q)
            RUN: begin
                if (done_i && illegal_insn_i)                 err = ERR_ILLEGAL;
                else if (done_i && !id_in_range)              err = ERR_ID_RANGE;
                else if (done_i && id_seen)                   err = ERR_DUP_ID;
                else if (acc_store && store_cnt_q == StoreMax) err = ERR_STORE_OVF;
                else if (!done_i && !acc_store && idle_q == IdleMax) err = ERR_TIMEOUT;

                // An illegal instruction still retires its ID, but its result is not kept.
                if (done_i && id_in_range && !id_seen) begin
                    bitmap_d[id_idx] = 1'b1;
                    if (done_cnt_q != '1) done_cnt_d = done_cnt_q + DoneCntW'(1);
                    if (!illegal_insn_i) last_result_d = result_i;
                end
                if (acc_store && store_cnt_q != '1) store_cnt_d = store_cnt_q + StoreCntW'(1);

                if (done_i || acc_store)  idle_d = '0;
                else if (idle_q != IdleMax) idle_d = idle_q + IdleW'(1);

                if (err != ERR_NONE) begin
                    state_d    = ERROR;
                    err_code_d = err;
                end else if ((&bitmap_d) && store_cnt_d == StoreMax) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_i) begin
                    state_d    = ERROR;
                    err_code_d = ERR_DUP_ID;
                end else if (acc_store) begin
                    state_d    = ERROR;
                    err_code_d = ERR_STORE_OVF;
                end
            end
            default: ;
        endcase

        sim_done_d  = (state_d == DONE);
        sim_error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            err_code_q    <= ERR_NONE;
            bitmap_q      <= '0;
            done_cnt_q    <= '0;
            store_cnt_q   <= '0;
            last_result_q <= '0;
            idle_q        <= '0;
            sim_done_q    <= 1'b0;
            sim_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_code_q    <= err_code_d;
            bitmap_q      <= bitmap_d;
            done_cnt_q    <= done_cnt_d;
            store_cnt_q   <= store_cnt_d;
            last_result_q <= last_result_d;
            idle_q        <= idle_d;
            sim_done_q    <= sim_done_d;
            sim_error_q   <= sim_error_d;
        end
    end

`ifdef STIMULUS_TRACKER_CHECKSUM_EN
    logic [DataWidth-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (acc_store && state_q != ERROR)
            checksum_d = {checksum_q[DataWidth-2:0], checksum_q[DataWidth-1]} ^ store_op_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign store_checksum_o = checksum_q;
`else
    logic store_op_unused;
    assign store_op_unused = ^store_op_i;
`endif

    assign sim_done_o    = sim_done_q;
    assign sim_error_o   = sim_error_q;
    assign error_code_o  = err_code_q;
    assign done_cnt_o    = done_cnt_q;
    assign store_cnt_o   = store_cnt_q;
    assign last_result_o = last_result_q;

endmodule
